imm_ext_arbiter: RTL and testbench
==================================

# imm_ext_arbiter

Shared immediate sign-extension unit with a two-requester round-robin arbiter. It serves the decode path (14-bit ALU/memory immediates) and the branch path (24-bit branch offsets) of the multicycle processor. Each request passes through a valid/ready handshake and is extended to 32 bits into a single registered result slot. The result is returned with its source ID and tag.

## Interface

- TAG_W, 4, width of the requester tag carried alongside each request

- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- r0_valid  input  1  requester 0 (decode) has a request
- r0_ready  output  1  requester 0 request accepted this cycle when high with r0_valid
- r0_imm  input  24  raw immediate field; bits [13:0] only used in 14-bit mode
- r0_sel24  input  1  1 = 24-bit extension, 0 = 14-bit extension
- r0_zx  input  1  1 = zero-extend (honoured only with IMM_EXT_ZX_EN)
- r0_tag  input  TAG_W  opaque tag echoed on result
- r1_valid, r1_ready, r1_imm, r1_sel24, r1_zx, r1_tag  same as above for requester 1 (branch)
- out_valid  output  1  result register holds a valid result
- out_ready  input  1  consumer takes result when high with out_valid
- out_data  output  32  extended immediate
- out_src  output  1  0 = requester 0, 1 = requester 1
- out_tag  output  TAG_W  tag of the request that produced out_data

## Operation

- State: IDLE (result slot empty) and FULL (out_valid=1).
- can_accept = !out_valid | out_ready.
- Arbitration:
  - Only one requester valid: it is granted.
  - Both valid: the requester not named by last_grant is granted.
  - last_grant updates only on an accepted transfer.
- rN_ready = can_accept & (grant == N). It is combinational from valids, out_ready and state. It never depends on rN_ready itself.
- Transfer: on rN_valid & rN_ready, the slot loads the following, and state goes to FULL:
  - 14-bit mode: out_data = {18{imm[13]}, imm[13:0]}.
  - 24-bit mode: out_data = {8{imm[23]}, imm[23:0]}.
  - out_src = N; out_tag = rN_tag.
- Drain:
  - out_valid & out_ready with no new transfer: state goes to IDLE.
  - Drain and transfer in the same cycle: state stays FULL with the new contents (back-to-back throughput of 1 per cycle).
- While FULL and out_ready=0: out_data, out_src and out_tag are held stable; both rN_ready are 0.
- Ignored fields: r*_imm[23:14] in 14-bit mode; rN_zx without the macro.

## Timing

- Reset (async assert, deasserted synchronously by the system):
  - out_valid=0, out_data=0, out_src=0, out_tag=0.
  - last_grant=1, so requester 0 wins the first contention.
  - r*_ready=1 once rst_n=1 and the slot is empty (combinational).
- Latency: request accepted at edge k, so out_valid=1 with the result after edge k (visible in cycle k+1).
- Throughput: one result per cycle with out_ready held high. With both requesters continuously valid, grants alternate 0,1,0,1.
- Reset mid-operation: a pending result is discarded, out_valid drops immediately, and no handshake completes in the reset cycle.
- A requester must hold valid and its fields stable until ready. The block does not check this.

## Configuration

- IMM_EXT_ZX_EN defined:
  - rN_zx=1 selects zero extension: {18'b0, imm[13:0]} or {8'b0, imm[23:0]}.
  - rN_zx=0 sign-extends as above.
- IMM_EXT_ZX_EN undefined: the rN_zx ports remain present but are ignored, and all extension is signed.

## Test plan

- Reset then r0 only: r0_imm=24'h002000, sel24=0, tag=3 -> next cycle out_valid=1, out_data=32'hFFFFE000, out_src=0, out_tag=3.
- r1 only: r1_imm=24'h7FFFFF, sel24=1 -> out_data=32'h007FFFFF. Then r1_imm=24'h800000 -> out_data=32'hFF800000.
- Both valid every cycle, out_ready=1, 6 cycles -> grants 0,1,0,1,0,1; one result per cycle with matching src/tag.
- Backpressure: out_ready=0 for 3 cycles with FULL slot and both requesters valid -> r0_ready=r1_ready=0, out_data stable; out_ready=1 -> same-cycle drain and refill.
- rst_n pulsed low while out_valid=1 -> out_valid=0 immediately, out_data=0; first post-reset contention granted to r0.
- With IMM_EXT_ZX_EN: r0_imm=24'h003FFF, sel24=0, zx=1 -> 32'h00003FFF. Without the macro, the same stimulus -> 32'hFFFFFFFF.

Source files
------------

// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter
//
// Shared immediate sign-extension unit. Two requesters (0 = decode path,
// 1 = branch path) compete for a single registered result slot. A
// round-robin arbiter picks between them, and the winner's immediate is
// extended to 32 bits. It is then stored with its source ID and tag.
//
// Optional feature: define IMM_EXT_ZX_EN to honour the rN_zx inputs
// (zero extension). Without the macro, all extension is signed and the
// rN_zx inputs are ignored.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   r0_* / r1_*          valid/ready request channels
//                          imm   24-bit raw field
//                          sel24 1 = 24-bit extension, 0 = 14-bit
//                          zx    zero-extend request
//                          tag   opaque TAG_W-bit tag
//   out_valid/out_ready  result handshake
//   out_data             32-bit extended immediate
//   out_src              requester that produced the result
//   out_tag              tag of that request

module imm_ext_arbiter #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             r0_valid,
   output logic             r0_ready,
   input  logic [23:0]      r0_imm,
   input  logic             r0_sel24,
   input  logic             r0_zx,
   input  logic [TAG_W-1:0] r0_tag,
   input  logic             r1_valid,
   output logic             r1_ready,
   input  logic [23:0]      r1_imm,
   input  logic             r1_sel24,
   input  logic             r1_zx,
   input  logic [TAG_W-1:0] r1_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic             out_src,
   output logic [TAG_W-1:0] out_tag
);

   typedef enum logic {IDLE, FULL} state_t;

   state_t      state;
   state_t      state_next;
   logic        last_grant;
   logic        can_accept;
   logic        fire0;
   logic        fire1;
   logic        load;
   logic [31:0] ext0;
   logic [31:0] ext1;

   // zx forces the fill bit to zero instead of copying the sign bit.
   function automatic logic [31:0] extend(input logic [23:0] imm,
                                          input logic        sel24,
                                          input logic        zx);
      logic [31:0] r;
      if (sel24)
         r = {{8{imm[23] & ~zx}}, imm};
      else
         r = {{18{imm[13] & ~zx}}, imm[13:0]};
      return r;
   endfunction

`ifdef IMM_EXT_ZX_EN
   assign ext0 = extend(r0_imm, r0_sel24, r0_zx);
   assign ext1 = extend(r1_imm, r1_sel24, r1_zx);
`else
   logic unused_zx;
   assign unused_zx = r0_zx ^ r1_zx;
   assign ext0 = extend(r0_imm, r0_sel24, 1'b0);
   assign ext1 = extend(r1_imm, r1_sel24, 1'b0);
`endif

   // State register. last_grant resets to 1 so requester 0 wins the
   // first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else begin
         state <= state_next;
         if (load)
            last_grant <= fire1;
      end
   end

   // Result slot. It is only written on an accepted transfer, so the
   // contents hold steady while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
         out_src  <= 1'b0;
         out_tag  <= '0;
      end else if (load) begin
         out_data <= fire1 ? ext1 : ext0;
         out_src  <= fire1;
         out_tag  <= fire1 ? r1_tag : r0_tag;
      end
   end

   // Next state. A refill wins over a drain, which keeps throughput at
   // one result per cycle.
   always_comb begin
      state_next = state;
      if (load)
         state_next = FULL;
      else if (out_valid && out_ready)
         state_next = IDLE;
   end

   // Handshake outputs. A requester is refused only when the other one
   // is also valid and has the round-robin turn. That is why both readies
   // are high in an idle empty slot. The readies are gated by rst_n so
   // that no request can be accepted while reset is held.
   always_comb begin
      out_valid  = (state == FULL);
      can_accept = !out_valid || out_ready;
      r0_ready   = rst_n && can_accept && (!r1_valid || last_grant);
      r1_ready   = rst_n && can_accept && (!r0_valid || !last_grant);
      fire0      = r0_valid && r0_ready;
      fire1      = r1_valid && r1_ready;
      load       = fire0 || fire1;
   end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb_imm_ext_arbiter
//
// Directed bench for imm_ext_arbiter. A table of per-cycle vectors covers
// single-requester extension cases and alternating contention. Hand-written
// sequences cover the following:
//   - reset values
//   - backpressure
//   - drain to empty
//   - reset while a result is pending
// The bench honours IMM_EXT_ZX_EN to pick the expected zero/sign results.

module tb_imm_ext_arbiter;

   localparam int TAG_W = 4;

`ifdef IMM_EXT_ZX_EN
   localparam logic [31:0] EXP_ZX14 = 32'h00003FFF;
   localparam logic [31:0] EXP_ZX24 = 32'h00800000;
`else
   localparam logic [31:0] EXP_ZX14 = 32'hFFFFFFFF;
   localparam logic [31:0] EXP_ZX24 = 32'hFF800000;
`endif

   logic             clk;
   logic             rst_n;
   logic             r0_valid, r0_ready, r0_sel24, r0_zx;
   logic [23:0]      r0_imm;
   logic [TAG_W-1:0] r0_tag;
   logic             r1_valid, r1_ready, r1_sel24, r1_zx;
   logic [23:0]      r1_imm;
   logic [TAG_W-1:0] r1_tag;
   logic             out_valid, out_ready, out_src;
   logic [31:0]      out_data;
   logic [TAG_W-1:0] out_tag;

   int assert_count;
   int fail_count;

   typedef struct {
      logic             r0_valid;
      logic [23:0]      r0_imm;
      logic             r0_sel24;
      logic             r0_zx;
      logic [TAG_W-1:0] r0_tag;
      logic             r1_valid;
      logic [23:0]      r1_imm;
      logic             r1_sel24;
      logic             r1_zx;
      logic [TAG_W-1:0] r1_tag;
      logic             out_ready;
      logic             exp_r0_ready;
      logic             exp_r1_ready;
      logic             exp_valid;
      logic [31:0]      exp_data;
      logic             exp_src;
      logic [TAG_W-1:0] exp_tag;
   } vec_t;

   vec_t vecs[13];

   imm_ext_arbiter #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_imm(r0_imm),
      .r0_sel24(r0_sel24), .r0_zx(r0_zx), .r0_tag(r0_tag),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_imm(r1_imm),
      .r1_sel24(r1_sel24), .r1_zx(r1_zx), .r1_tag(r1_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_src(out_src), .out_tag(out_tag)
   );

   // Free-running 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic r0v, input logic [23:0] r0i, input logic r0s, input logic r0z,
      input logic [TAG_W-1:0] r0t,
      input logic r1v, input logic [23:0] r1i, input logic r1s, input logic r1z,
      input logic [TAG_W-1:0] r1t,
      input logic ordy, input logic e0, input logic e1, input logic ev,
      input logic [31:0] ed, input logic es, input logic [TAG_W-1:0] et);
      vec_t v;
      v.r0_valid = r0v; v.r0_imm = r0i; v.r0_sel24 = r0s; v.r0_zx = r0z;
      v.r0_tag = r0t;
      v.r1_valid = r1v; v.r1_imm = r1i; v.r1_sel24 = r1s; v.r1_zx = r1z;
      v.r1_tag = r1t;
      v.out_ready = ordy; v.exp_r0_ready = e0; v.exp_r1_ready = e1;
      v.exp_valid = ev; v.exp_data = ed; v.exp_src = es; v.exp_tag = et;
      return v;
   endfunction

   // One comparison: counts it and reports a mismatch
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assert_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      r0_valid = v.r0_valid; r0_imm = v.r0_imm; r0_sel24 = v.r0_sel24;
      r0_zx = v.r0_zx; r0_tag = v.r0_tag;
      r1_valid = v.r1_valid; r1_imm = v.r1_imm; r1_sel24 = v.r1_sel24;
      r1_zx = v.r1_zx; r1_tag = v.r1_tag;
      out_ready = v.out_ready;
   endtask

   task automatic checkResult(input string tag, input logic ev,
                              input logic [31:0] ed, input logic es,
                              input logic [TAG_W-1:0] et);
      checkOutput({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, ev});
      checkOutput({tag, " out_data"}, out_data, ed);
      checkOutput({tag, " out_src"}, {31'b0, out_src}, {31'b0, es});
      checkOutput({tag, " out_tag"}, {28'b0, out_tag}, {28'b0, et});
   endtask

   initial begin
      assert_count = 0;
      fail_count   = 0;

      // Single-requester cases, starting from reset (last_grant = 1).
      vecs[0]  = mk(1, 24'h002000, 0, 0, 4'd3,  0, 24'h0, 0, 0, 4'd0,
                    1, 1, 0, 1, 32'hFFFFE000, 0, 4'd3);
      vecs[1]  = mk(0, 24'h0, 0, 0, 4'd0,  1, 24'h7FFFFF, 1, 0, 4'd5,
                    1, 0, 1, 1, 32'h007FFFFF, 1, 4'd5);
      vecs[2]  = mk(0, 24'h0, 0, 0, 4'd0,  1, 24'h800000, 1, 0, 4'd6,
                    1, 0, 1, 1, 32'hFF800000, 1, 4'd6);
      vecs[3]  = mk(1, 24'h003FFF, 0, 1, 4'd7,  0, 24'h0, 0, 0, 4'd0,
                    1, 1, 0, 1, EXP_ZX14, 0, 4'd7);
      vecs[4]  = mk(1, 24'hFFC001, 0, 0, 4'd8,  0, 24'h0, 0, 0, 4'd0,
                    1, 1, 0, 1, 32'h00000001, 0, 4'd8);
      vecs[5]  = mk(0, 24'h0, 0, 0, 4'd0,  1, 24'h001FFF, 0, 0, 4'd9,
                    1, 0, 1, 1, 32'h00001FFF, 1, 4'd9);
      vecs[6]  = mk(0, 24'h0, 0, 0, 4'd0,  1, 24'h800000, 1, 1, 4'd10,
                    1, 0, 1, 1, EXP_ZX24, 1, 4'd10);
      // Contention with last_grant = 1: grants alternate 0,1,0,1,0,1.
      // Each loser holds its request until it is granted.
      vecs[7]  = mk(1, 24'h000010, 0, 0, 4'd1,  1, 24'h000100, 1, 0, 4'd2,
                    1, 1, 0, 1, 32'h00000010, 0, 4'd1);
      vecs[8]  = mk(1, 24'h002001, 0, 0, 4'd3,  1, 24'h000100, 1, 0, 4'd2,
                    1, 0, 1, 1, 32'h00000100, 1, 4'd2);
      vecs[9]  = mk(1, 24'h002001, 0, 0, 4'd3,  1, 24'hF00000, 1, 0, 4'd4,
                    1, 1, 0, 1, 32'hFFFFE001, 0, 4'd3);
      vecs[10] = mk(1, 24'h000005, 0, 0, 4'd5,  1, 24'hF00000, 1, 0, 4'd4,
                    1, 0, 1, 1, 32'hFFF00000, 1, 4'd4);
      vecs[11] = mk(1, 24'h000005, 0, 0, 4'd5,  1, 24'h0ABCDE, 1, 0, 4'd6,
                    1, 1, 0, 1, 32'h00000005, 0, 4'd5);
      vecs[12] = mk(1, 24'h000006, 0, 0, 4'd7,  1, 24'h0ABCDE, 1, 0, 4'd6,
                    1, 0, 1, 1, 32'h000ABCDE, 1, 4'd6);

      // Reset: all outputs zero. Both readies are high once released
      // with the slot empty.
      rst_n = 1'b0;
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      #1;
      checkResult("reset", 0, 32'h0, 0, 4'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("reset r0_ready", {31'b0, r0_ready}, 32'd1);
      checkOutput("reset r1_ready", {31'b0, r1_ready}, 32'd1);

      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i]);
         #1;
         if (vecs[i].r0_valid)
            checkOutput($sformatf("vec%0d r0_ready", i), {31'b0, r0_ready},
                        {31'b0, vecs[i].exp_r0_ready});
         if (vecs[i].r1_valid)
            checkOutput($sformatf("vec%0d r1_ready", i), {31'b0, r1_ready},
                        {31'b0, vecs[i].exp_r1_ready});
         @(posedge clk);
         #1;
         checkResult($sformatf("vec%0d", i), vecs[i].exp_valid,
                     vecs[i].exp_data, vecs[i].exp_src, vecs[i].exp_tag);
      end

      // Backpressure. last_grant is now 1, so r0 wins and fills the slot.
      applyStimulus(mk(1, 24'h000006, 0, 0, 4'd7, 1, 24'h123456, 1, 0, 4'd8,
                       1, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      checkResult("bp fill", 1, 32'h00000006, 0, 4'd7);
      // Stall for 3 cycles. r0 presents a new request and r1 holds its own.
      r0_imm = 24'h000007; r0_tag = 4'd9; out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         checkOutput($sformatf("bp%0d r0_ready", c), {31'b0, r0_ready}, 32'd0);
         checkOutput($sformatf("bp%0d r1_ready", c), {31'b0, r1_ready}, 32'd0);
         @(posedge clk);
         #1;
         checkResult($sformatf("bp%0d", c), 1, 32'h00000006, 0, 4'd7);
      end
      // Release: the slot drains and refills in the same cycle (r1's turn).
      out_ready = 1'b1;
      #1;
      checkOutput("bp release r0_ready", {31'b0, r0_ready}, 32'd0);
      checkOutput("bp release r1_ready", {31'b0, r1_ready}, 32'd1);
      @(posedge clk);
      #1;
      checkResult("bp refill", 1, 32'h00123456, 1, 4'd8);

      // Drain to empty with no requests
      r0_valid = 1'b0; r1_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("drain out_valid", {31'b0, out_valid}, 32'd0);

      // Reset while a result is pending. r0 fills the slot, leaving
      // last_grant = 0, so only reset can hand the next contention back to r0.
      applyStimulus(mk(1, 24'h000002, 0, 0, 4'd2, 0, 0, 0, 0, 0,
                       1, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      checkResult("pre-reset", 1, 32'h00000002, 0, 4'd2);
      applyStimulus(mk(1, 24'h000003, 0, 0, 4'd11, 1, 24'h000004, 0, 0, 4'd12,
                       1, 0, 0, 0, 0, 0, 0));
      rst_n = 1'b0;
      #1;
      checkResult("mid-reset", 0, 32'h0, 0, 4'd0);
      checkOutput("mid-reset r0_ready", {31'b0, r0_ready}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("mid-reset held out_valid", {31'b0, out_valid}, 32'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("post-reset r0_ready", {31'b0, r0_ready}, 32'd1);
      checkOutput("post-reset r1_ready", {31'b0, r1_ready}, 32'd0);
      @(posedge clk);
      #1;
      checkResult("post-reset", 1, 32'h00000003, 0, 4'd11);

      $display("End of test - %0d assertions evaluated, %0d failures",
               assert_count, fail_count);
      $finish;
   end

endmodule
